crop_window_gate: RTL

- Downstream consumer of the per-frame X-end measurement stage.
- Takes the measured window edges (XSTART/XEND, one value pair per frame) and applies them to the following frame's 640x480 pixel stream.
- Passes only pixels inside the window, re-based to window-relative coordinates, for the capture/storage path.
- Validates each measured window; falls back to the last good window when a measurement is rejected.

---
 rtl/crop_pkg.sv | 13 +
 rtl/frame_xy_counter.sv | 50 +++++
 rtl/crop_window_gate.sv | 108 ++++++++++
 3 files changed

// File: rtl/crop_pkg.sv
// Shared frame geometry, coordinate width and FSM encoding for the crop/X-end stages.
package crop_pkg;
    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam int Y_START  = 120;
    localparam int Y_END    = 190;
    localparam int COORD_W  = 16;

    typedef enum logic {
        ST_SYNC = 1'b0,
        ST_RUN  = 1'b1
    } state_t;
endpackage

// File: rtl/frame_xy_counter.sv
// Raster X/Y position counter advancing on valid pixels; flags first and last pixel of a frame.
module frame_xy_counter
    import crop_pkg::*;
#(
    parameter int H_ACT = H_ACTIVE,
    parameter int V_ACT = V_ACTIVE
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               adv_i,
    output logic [COORD_W-1:0] x_o,
    output logic [COORD_W-1:0] y_o,
    output logic               first_o,
    output logic               last_o
);
    logic [COORD_W-1:0] x_q, x_d;
    logic [COORD_W-1:0] y_q, y_d;
    logic               x_end, y_end;

    assign x_end = (x_q == COORD_W'(H_ACT - 1));
    assign y_end = (y_q == COORD_W'(V_ACT - 1));

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (adv_i) begin
            if (x_end) begin
                x_d = '0;
                y_d = y_end ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x_o     = x_q;
    assign y_o     = y_q;
    assign first_o = (x_q == '0) && (y_q == '0);
    assign last_o  = x_end && y_end;
endmodule

// File: rtl/crop_window_gate.sv
// Gates a raster stream to a per-frame measured X window and fixed Y band, re-basing coordinates.
// Latency 1 cycle; rejected window measurements fall back to the last accepted window.
module crop_window_gate
    import crop_pkg::*;
#(
    parameter int H_ACT      = H_ACTIVE,
    parameter int V_ACT      = V_ACTIVE,
    parameter int Y_FIRST    = Y_START,
    parameter int Y_LAST     = Y_END,
    parameter int DEF_XSTART = 160,
    parameter int DEF_XEND   = 480,
    parameter int MIN_WIDTH  = 8
) (
    input  logic                iCLK,
    input  logic                iRST,
    input  logic [9:0]          iDATA,
    input  logic                iDVAL,
    input  logic [COORD_W-1:0]  iXSTART,
    input  logic [COORD_W-1:0]  iXEND,
    output logic [9:0]          oDATA,
    output logic                oDVAL,
    output logic [COORD_W-1:0]  oX,
    output logic [COORD_W-1:0]  oY,
    output logic                oFRAME_DONE,
    output logic                oWIN_VALID,
    output logic [7:0]          oREJ_CNT
);
    state_t             state_q;
    logic [COORD_W-1:0] xs_q, xe_q;
    logic [9:0]         data_q;
    logic               dval_q, done_q, win_valid_q;
    logic [COORD_W-1:0] ox_q, oy_q;
    logic [7:0]         rej_q;

    logic [COORD_W-1:0] x, y;
    logic               first_px, last_px;

    frame_xy_counter #(
        .H_ACT (H_ACT),
        .V_ACT (V_ACT)
    ) u_xy (
        .clk_i   (iCLK),
        .rst_i   (iRST),
        .adv_i   (iDVAL),
        .x_o     (x),
        .y_o     (y),
        .first_o (first_px),
        .last_o  (last_px)
    );

    logic               latch, accept;
    logic [COORD_W:0]   min_end;
    logic [COORD_W-1:0] xs_sel, xe_sel;
    logic               in_win;

    // 17-bit compare so iXSTART near full scale cannot wrap past the minimum width.
    assign min_end = {1'b0, iXSTART} + (COORD_W+1)'(MIN_WIDTH);
    assign accept  = ({1'b0, iXEND} >= min_end) && (iXEND <= COORD_W'(H_ACT - 1));
    assign latch   = iDVAL && ((state_q == ST_SYNC) || first_px);

    // The latching pixel already sees the freshly accepted window.
    assign xs_sel = (latch && accept) ? iXSTART : xs_q;
    assign xe_sel = (latch && accept) ? iXEND   : xe_q;
    assign in_win = iDVAL && (x >= xs_sel) && (x <= xe_sel)
                 && (y >= COORD_W'(Y_FIRST)) && (y <= COORD_W'(Y_LAST));

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q     <= ST_SYNC;
            xs_q        <= COORD_W'(DEF_XSTART);
            xe_q        <= COORD_W'(DEF_XEND);
            data_q      <= '0;
            dval_q      <= 1'b0;
            ox_q        <= '0;
            oy_q        <= '0;
            done_q      <= 1'b0;
            win_valid_q <= 1'b0;
            rej_q       <= '0;
        end else begin
            if (latch) begin
                state_q <= ST_RUN;
                if (accept) begin
                    xs_q        <= iXSTART;
                    xe_q        <= iXEND;
                    win_valid_q <= 1'b1;
                end else begin
                    win_valid_q <= 1'b0;
                    if (rej_q != 8'hFF) rej_q <= rej_q + 1'b1;
                end
            end
            dval_q <= in_win;
            data_q <= in_win ? iDATA : '0;
            if (in_win) begin
                ox_q <= x - xs_sel;
                oy_q <= y - COORD_W'(Y_FIRST);
            end
            done_q <= iDVAL && last_px;
        end
    end

    assign oDATA       = data_q;
    assign oDVAL       = dval_q;
    assign oX          = ox_q;
    assign oY          = oy_q;
    assign oFRAME_DONE = done_q;
    assign oWIN_VALID  = win_valid_q;
    assign oREJ_CNT    = rej_q;
endmodule
